// File: rtl/nios_mult_pipe.sv
// Pipelined Nios-style multiplier: MUL / MULXSS / MULXSU / MULXUU built from four half-width partial products.
// Latency: 2 + OUT_REG cycles from accept to out_valid; one op per cycle while the consumer accepts.
// Backpressure: one global enable stalls every stage while the output is held; in_ready is that enable.
module nios_mult_pipe #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 5,
    parameter int OUT_REG   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_src1,
    input  logic [WIDTH-1:0]     in_src2,
    input  logic [1:0]           in_op,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int HALF = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXSS = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXUU = 2'b11
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0]     pll;
        logic [WIDTH-1:0]     plh;
        logic [WIDTH-1:0]     phl;
        logic [WIDTH-1:0]     phh;
        logic [WIDTH-1:0]     a;
        logic [WIDTH-1:0]     b;
        logic                 a_sgn;
        logic                 b_sgn;
        logic [1:0]           op;
        logic [TAG_WIDTH-1:0] tag;
    } p1_t;

    typedef struct packed {
        logic [WIDTH-1:0]     result;
        logic [TAG_WIDTH-1:0] tag;
    } res_t;

    logic en;
    logic v1, v2;
    p1_t  p1, p1_d;
    res_t p2, p2_d;

    assign en       = (~out_valid | out_ready) & ~flush;
    assign in_ready = en;

    // Operands are zero-extended to WIDTH so each product is a true HALF x HALF unsigned multiply.
    always_comb begin
        p1_d       = '0;
        p1_d.pll   = {{HALF{1'b0}}, in_src1[HALF-1:0]}    * {{HALF{1'b0}}, in_src2[HALF-1:0]};
        p1_d.plh   = {{HALF{1'b0}}, in_src1[HALF-1:0]}    * {{HALF{1'b0}}, in_src2[WIDTH-1:HALF]};
        p1_d.phl   = {{HALF{1'b0}}, in_src1[WIDTH-1:HALF]} * {{HALF{1'b0}}, in_src2[HALF-1:0]};
        p1_d.phh   = {{HALF{1'b0}}, in_src1[WIDTH-1:HALF]} * {{HALF{1'b0}}, in_src2[WIDTH-1:HALF]};
        p1_d.a     = in_src1;
        p1_d.b     = in_src2;
        p1_d.a_sgn = in_src1[WIDTH-1];
        p1_d.b_sgn = in_src2[WIDTH-1];
        p1_d.op    = in_op;
        p1_d.tag   = in_tag;
    end

    logic [PW-1:0] uprod, corr_a, corr_b, prod;
    logic          a_signed, b_signed;

    always_comb begin
        uprod = {{WIDTH{1'b0}}, p1.pll}
              + ({{WIDTH{1'b0}}, p1.plh} << HALF)
              + ({{WIDTH{1'b0}}, p1.phl} << HALF)
              + {p1.phh, {WIDTH{1'b0}}};
        a_signed = (p1.op == OP_MULXSS) || (p1.op == OP_MULXSU);
        b_signed = (p1.op == OP_MULXSS);
        // Two's-complement fix-up: a negative operand contributes -2^WIDTH times the other operand.
        corr_a = (a_signed && p1.a_sgn) ? {p1.b, {WIDTH{1'b0}}} : '0;
        corr_b = (b_signed && p1.b_sgn) ? {p1.a, {WIDTH{1'b0}}} : '0;
        prod   = uprod - corr_a - corr_b;
        p2_d        = '0;
        p2_d.tag    = p1.tag;
        p2_d.result = (p1.op == OP_MUL) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            p1 <= '0;
            v2 <= 1'b0;
            p2 <= '0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (en) begin
            v1 <= in_valid;
            v2 <= v1;
            if (in_valid) p1 <= p1_d;
            if (v1)       p2 <= p2_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic v3;
            res_t p3;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v3 <= 1'b0;
                    p3 <= '0;
                end else if (flush) begin
                    v3 <= 1'b0;
                end else if (en) begin
                    v3 <= v2;
                    if (v2) p3 <= p2;
                end
            end
            assign out_valid  = v3;
            assign out_result = p3.result;
            assign out_tag    = p3.tag;
        end else begin : g_out_direct
            assign out_valid  = v2;
            assign out_result = p2.result;
            assign out_tag    = p2.tag;
        end
    endgenerate

endmodule

// File: tb/tb_nios_mult_pipe.sv
// Directed bench: WIDTH=32/OUT_REG=1 instance for function, stall, flush and reset;
// WIDTH=16/OUT_REG=0 instance for latency-2 arithmetic vectors.
module tb_nios_mult_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // WIDTH=32, OUT_REG=1
    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [31:0] a_src1, a_src2, a_out_result;
    logic [1:0]  a_op;
    logic [4:0]  a_tag, a_out_tag;

    // WIDTH=16, OUT_REG=0
    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [15:0] b_src1, b_src2, b_out_result;
    logic [1:0]  b_op;
    logic [4:0]  b_tag, b_out_tag;

    nios_mult_pipe #(.WIDTH(32), .TAG_WIDTH(5), .OUT_REG(1)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_src1(a_src1), .in_src2(a_src2), .in_op(a_op), .in_tag(a_tag),
        .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_result(a_out_result), .out_tag(a_out_tag)
    );

    nios_mult_pipe #(.WIDTH(16), .TAG_WIDTH(5), .OUT_REG(0)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_src1(b_src1), .in_src2(b_src2), .in_op(b_op), .in_tag(b_tag),
        .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_result(b_out_result), .out_tag(b_out_tag)
    );

    localparam logic [1:0] MUL = 2'b00, XSS = 2'b01, XSU = 2'b10, XUU = 2'b11;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single op on the 32-bit pipe; result must appear exactly 3 edges after the accept edge.
    task automatic run_a(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [4:0] tag, input logic [31:0] exp);
        a_src1 = a; a_src2 = b; a_op = op; a_tag = tag; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        step();
        check({name, "_early"}, a_out_valid, 0);
        step();
        check({name, "_vld"}, a_out_valid, 1);
        check({name, "_res"}, a_out_result, exp);
        check({name, "_tag"}, a_out_tag, tag);
        step();
    endtask

    // Single op on the 16-bit pipe; latency 2.
    task automatic run_b(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic [4:0] tag, input logic [15:0] exp);
        b_src1 = a; b_src2 = b; b_op = op; b_tag = tag; b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        check({name, "_early"}, b_out_valid, 0);
        step();
        check({name, "_vld"}, b_out_valid, 1);
        check({name, "_res"}, b_out_result, exp);
        check({name, "_tag"}, b_out_tag, tag);
        step();
    endtask

    logic seen;

    initial begin
        reset = 1'b1;
        a_in_valid = 0; a_src1 = 0; a_src2 = 0; a_op = 0; a_tag = 0; a_flush = 0; a_out_ready = 1;
        b_in_valid = 0; b_src1 = 0; b_src2 = 0; b_op = 0; b_tag = 0; b_flush = 0; b_out_ready = 1;
        step();
        step();
        check("rst_ovld", a_out_valid, 0);
        check("rst_ores", a_out_result, 0);
        check("rst_otag", a_out_tag, 0);
        check("rst_b_ovld", b_out_valid, 0);
        reset = 1'b0;
        #1;
        check("rst_irdy", a_in_ready, 1);
        step();

        // Arithmetic on the 32-bit pipe
        run_a("mul_basic", 32'h0001_0003, 32'h0002_0005, MUL, 5'd9,  32'h000B_000F);
        run_a("ff_xss",    32'hFFFF_FFFF, 32'hFFFF_FFFF, XSS, 5'd1,  32'h0000_0000);
        run_a("ff_xsu",    32'hFFFF_FFFF, 32'hFFFF_FFFF, XSU, 5'd2,  32'hFFFF_FFFF);
        run_a("ff_xuu",    32'hFFFF_FFFF, 32'hFFFF_FFFF, XUU, 5'd3,  32'hFFFF_FFFE);
        run_a("ff_mul",    32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL, 5'd4,  32'h0000_0001);
        run_a("m8_xss",    32'h8000_0000, 32'h8000_0000, XSS, 5'd5,  32'h4000_0000);
        run_a("m8_xuu",    32'h8000_0000, 32'h8000_0000, XUU, 5'd6,  32'h4000_0000);
        run_a("m8_xsu",    32'h8000_0000, 32'h8000_0000, XSU, 5'd31, 32'hC000_0000);

        // Back-pressure: three ops back-to-back, output stalled for 4 cycles
        for (int t = 1; t <= 3; t++) begin
            a_src1 = 32'(t); a_src2 = 32'd3; a_op = MUL; a_tag = 5'(t); a_in_valid = 1'b1;
            step();
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("bp_irdy", a_in_ready, 0);
            check("bp_ovld", a_out_valid, 1);
            check("bp_otag", a_out_tag, 1);
            step();
        end
        a_out_ready = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            check("bp_seq_vld", a_out_valid, 1);
            check("bp_seq_tag", a_out_tag, 5'(t));
            check("bp_seq_res", a_out_result, 32'(3 * t));
            step();
        end
        check("bp_drained", a_out_valid, 0);

        // Flush: two ops in flight, flush alongside a new in_valid
        for (int t = 1; t <= 2; t++) begin
            a_src1 = 32'd7; a_src2 = 32'(t); a_op = MUL; a_tag = 5'(20 + t); a_in_valid = 1'b1;
            step();
        end
        a_tag = 5'd23; a_flush = 1'b1;
        #1;
        check("fl_irdy", a_in_ready, 0);
        step();
        a_flush = 1'b0; a_in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (a_out_valid) seen = 1'b1;
            step();
        end
        check("fl_no_out", seen, 0);
        run_a("fl_after", 32'h0000_1234, 32'h0000_0100, MUL, 5'd24, 32'h0012_3400);

        // Asynchronous reset with three ops in flight
        for (int t = 1; t <= 3; t++) begin
            a_src1 = 32'd5; a_src2 = 32'(t); a_op = MUL; a_tag = 5'(10 + t); a_in_valid = 1'b1;
            step();
        end
        a_in_valid = 1'b0;
        check("ar_pre_vld", a_out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_ovld", a_out_valid, 0);
        check("ar_ores", a_out_result, 0);
        step();
        #2;
        reset = 1'b0;
        #1;
        check("ar_irdy", a_in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (a_out_valid) seen = 1'b1;
            step();
        end
        check("ar_no_stale", seen, 0);

        // 16-bit pipe, no output register
        check("b_irdy", b_in_ready, 1);
        run_b("b_mul",     16'h1234, 16'h0010, MUL, 5'd1, 16'h2340);
        run_b("b_xuu_ff",  16'hFFFF, 16'hFFFF, XUU, 5'd2, 16'hFFFE);
        run_b("b_xss_m1",  16'hFFFF, 16'h0002, XSS, 5'd3, 16'hFFFF);
        run_b("b_xsu_m8",  16'h8000, 16'hFFFF, XSU, 5'd4, 16'h8000);
        run_b("b_xss_m8",  16'h8000, 16'h8000, XSS, 5'd5, 16'h4000);
        run_b("b_xuu_mix", 16'h1234, 16'h5678, XUU, 5'd6, 16'h0626);
        run_b("b_mul_mix", 16'h1234, 16'h5678, MUL, 5'd7, 16'h0060);
        run_b("b_xsu_7f",  16'h7FFF, 16'hFFFF, XSU, 5'd8, 16'h7FFE);
        run_b("b_xss_neg", 16'hFFFE, 16'hFFFD, XSS, 5'd9, 16'h0000);
        run_b("b_mul_neg", 16'hFFFE, 16'hFFFD, MUL, 5'd10, 16'h0006);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nios_mult_pipe.md
Name: nios_mult_pipe

Overview:
- Parametrised, handshaked successor to the CPU multiply cell.
- Forms the full 2*WIDTH-bit product from four registered half-width partial products, applies signed/unsigned correction, and returns the low or high WIDTH bits for the selected Nios-style op.
- Sits between the E-stage operand mux and the M/W writeback path.
- Supports back-pressure, flush, and tag passthrough for destination-register tracking.

Parameters:
WIDTH, 32, operand and result width; even, >= 4; HALF = WIDTH/2 is derived internally.
TAG_WIDTH, 5, width of the sideband tag carried alongside each op.
OUT_REG, 1, 0 or 1; adds one output register stage, giving latency 2+OUT_REG.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  operand set present.
in_ready  out  1  block can accept; combinational.
in_src1  in  WIDTH  operand A.
in_src2  in  WIDTH  operand B.
in_op  in  2  00 MUL (low), 01 MULXSS (high, s*s), 10 MULXSU (high, A signed * B unsigned), 11 MULXUU (high, u*u).
in_tag  in  TAG_WIDTH  sideband, returned unchanged with the result.
flush  in  1  kill all in-flight ops; synchronous.
out_valid  out  1  result present.
out_ready  in  1  consumer accepts.
out_result  out  WIDTH  selected product bits.
out_tag  out  TAG_WIDTH  tag of the op in out_result.

Behaviour:
- Reset (async, reset=1): all stage valids, out_valid, out_result, out_tag and all pipeline data registers = 0.
- After reset deassertion: in_ready=1.
- Global advance: en = (~out_valid | out_ready) & ~flush. in_ready = en. The op is accepted when in_valid & in_ready.
- All stages advance together on en; stage valids shift and bubbles propagate. No intra-pipe bubble collapsing.
- Stage 1 (P1), on accept, registers:
  - pll = A[HALF-1:0]*B[HALF-1:0]
  - plh = A[HALF-1:0]*B[WIDTH-1:HALF]
  - phl = A[WIDTH-1:HALF]*B[HALF-1:0]
  - phh = A[WIDTH-1:HALF]*B[WIDTH-1:HALF]
  - All four are unsigned, WIDTH bits each. Also registers op, tag, A sign bit, B sign bit, and A, B (needed for correction).
- Stage 2 (P2):
  - Unsigned product U = pll + (plh<<HALF) + (phl<<HALF) + (phh<<WIDTH), computed mod 2^(2*WIDTH).
  - Signed correction: subtract (B<<WIDTH) if A is treated signed and A[MSB]=1; subtract (A<<WIDTH) if B is treated signed and B[MSB]=1.
  - A is signed for MULXSS and MULXSU; B is signed for MULXSS only. MUL uses U directly (low bits are sign-agnostic).
  - Selection: MUL -> P[WIDTH-1:0]; other ops -> P[2*WIDTH-1:WIDTH].
  - With OUT_REG=0, the P2 register drives out_*. With OUT_REG=1, a P3 register holds the result and P3 drives out_*.
- Latency: accept in cycle N -> out_valid in cycle N+2+OUT_REG, provided en stays 1.
- Back-pressure: when out_valid=1 and out_ready=0, the whole pipe holds. Data, tags and valids are stable, and in_ready=0.
  - Holding with a full pipe loses nothing; results emerge in strict issue order.
- Throughput: one op per cycle while out_ready=1.
- Flush:
  - In the flush cycle, all stage valids and out_valid clear at the next edge; data registers may keep stale values.
  - in_ready=0 while flush=1, so an in_valid in the same cycle is not accepted.
  - flush and out_ready both high: the output is dropped, not counted as delivered.
- Reset mid-operation: in-flight ops are discarded immediately and asynchronously; no partial result appears after release.
- Arithmetic:
  - Partial products are HALF x HALF -> WIDTH bits.
  - Accumulation is 2*WIDTH bits wide; carries out of bit 2*WIDTH-1 are discarded.
  - No saturation, no overflow flag.

Test Plan:
- WIDTH=32, OUT_REG=1, MUL 0x00010003 * 0x00020005 -> out_result=0x000B000F exactly 3 cycles after accept; out_tag equals the issued tag.
- A=B=0xFFFFFFFF: MULXSS -> 0x00000000; MULXSU -> 0xFFFFFFFF; MULXUU -> 0xFFFFFFFE; MUL -> 0x00000001.
- A=B=0x80000000: MULXSS -> 0x40000000; MULXUU -> 0x40000000; MULXSU -> 0xC0000000.
- Back-pressure:
  - Stimulus: issue tags 1,2,3 back-to-back, hold out_ready=0 for 4 cycles, then release.
  - Required: in_ready=0 while the output is stalled; results appear in order with tags 1,2,3 on consecutive cycles, and none are duplicated or lost.
- Flush: issue 2 ops, then flush=1 with in_valid=1 on the next cycle -> no out_valid for the killed ops, the same-cycle op is not accepted, and the next op after flush returns the correct result.
- Reset: assert reset asynchronously mid-cycle with 3 ops in flight -> out_valid=0 and out_result=0 immediately; after release in_ready=1 and no stale results appear.
- Randomized sweep also at WIDTH=16 and OUT_REG=0: results match a reference model for all ops, including latency 2.
